// File: rtl/minirv_pkg.sv
// Shared miniRV definitions: write-back source selects, load funct3 codes, WB register payload.
package minirv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;
   localparam logic [1:0] WB_SEL_IMM  = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // MEM/WB pipeline register contents
   typedef struct packed {
      logic            valid;
      logic            rf_we;
      logic [4:0]      rd;
      logic [1:0]      wb_sel;
      logic [2:0]      funct3;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] dram_rd;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] imm;
   } wb_reg_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle plus the register-file write port and retire status of the WB stage.
interface wb_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            mem_valid;
   logic            mem_rf_we;
   logic [4:0]      mem_rd;
   logic [1:0]      mem_wb_sel;
   logic [2:0]      mem_funct3;
   logic [XLEN-1:0] mem_alu_res;
   logic [XLEN-1:0] mem_dram_rd;
   logic [XLEN-1:0] mem_pc4;
   logic [XLEN-1:0] mem_imm;
   logic            stall;
   logic            flush;

   logic            rf_we;
   logic [4:0]      rf_wR;
   logic [XLEN-1:0] rf_wD;
   logic            wb_valid;
   logic [31:0]     instret;

   // Upstream pipeline / pipeline control side
   modport master (
      output mem_valid, mem_rf_we, mem_rd, mem_wb_sel, mem_funct3,
             mem_alu_res, mem_dram_rd, mem_pc4, mem_imm, stall, flush,
      input  rf_we, rf_wR, rf_wD, wb_valid, instret
   );

   // Write-back stage side
   modport slave (
      input  mem_valid, mem_rf_we, mem_rd, mem_wb_sel, mem_funct3,
             mem_alu_res, mem_dram_rd, mem_pc4, mem_imm, stall, flush,
      output rf_we, rf_wR, rf_wD, wb_valid, instret
   );
endinterface

// File: rtl/load_ext.sv
// Sub-word load alignment and sign/zero extension (combinational).
module load_ext
   import minirv_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] ext
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   // Pick the addressed byte and half; off[0] does not matter for halves
   always_comb begin
      byte_c = word[7:0];
      half_c = word[15:0];
      case (off)
         2'd1:    byte_c = word[15:8];
         2'd2:    byte_c = word[23:16];
         2'd3:    byte_c = word[31:24];
         default: byte_c = word[7:0];
      endcase
      if (off[1]) half_c = word[31:16];
   end

   // Extend according to the load size/sign code; unknown codes act as lw
   always_comb begin
      ext = word;
      case (funct3)
         F3_LB:   ext = {{24{byte_c[7]}}, byte_c};
         F3_LBU:  ext = {24'd0, byte_c};
         F3_LH:   ext = {{16{half_c[15]}}, half_c};
         F3_LHU:  ext = {16'd0, half_c};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// miniRV write-back stage: MEM/WB register, write-data select, retire counter.
// Optional WB_LOAD_EXT_EN macro enables sub-word load extraction (otherwise LOAD returns the raw word).
module wb_stage
   import minirv_pkg::*;
#(
   parameter int unsigned XLEN = minirv_pkg::XLEN
)(
   input  logic       clk,
   input  logic       rst_n,
   wb_stage_if.slave  bus
);

   wb_reg_t         wb_q;
   wb_reg_t         wb_d;
   logic [31:0]     instret_q;
   logic [XLEN-1:0] load_val_c;
   logic [XLEN-1:0] wd_c;

   // Gather the incoming MEM-stage fields into the register payload
   always_comb begin
      wb_d         = '0;
      wb_d.valid   = bus.mem_valid;
      wb_d.rf_we   = bus.mem_rf_we;
      wb_d.rd      = bus.mem_rd;
      wb_d.wb_sel  = bus.mem_wb_sel;
      wb_d.funct3  = bus.mem_funct3;
      wb_d.alu_res = bus.mem_alu_res;
      wb_d.dram_rd = bus.mem_dram_rd;
      wb_d.pc4     = bus.mem_pc4;
      wb_d.imm     = bus.mem_imm;
   end

   // MEM/WB register: reset, then flush bubble, then stall hold, else load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_q <= '0;
      end else if (bus.flush) begin
         wb_q <= '0;
      end else if (!bus.stall) begin
         wb_q <= wb_d;
      end
   end

   // Retire counter: a valid entry leaves WB when not held, or when flushed out
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instret_q <= 32'd0;
      end else if (wb_q.valid && (!bus.stall || bus.flush)) begin
         instret_q <= instret_q + 32'd1;
      end
   end

`ifdef WB_LOAD_EXT_EN
   load_ext u_load_ext (
      .word   (wb_q.dram_rd),
      .off    (wb_q.alu_res[1:0]),
      .funct3 (wb_q.funct3),
      .ext    (load_val_c)
   );
`else
   logic unused_funct3_c;
   assign unused_funct3_c = ^wb_q.funct3;
   assign load_val_c      = wb_q.dram_rd;
`endif

   // Write-data source select from registered fields only
   always_comb begin
      wd_c = wb_q.alu_res;
      case (wb_q.wb_sel)
         WB_SEL_ALU:  wd_c = wb_q.alu_res;
         WB_SEL_LOAD: wd_c = load_val_c;
         WB_SEL_PC4:  wd_c = wb_q.pc4;
         WB_SEL_IMM:  wd_c = wb_q.imm;
         default:     wd_c = wb_q.alu_res;
      endcase
   end

   // Register-file port; x0 writes are suppressed
   assign bus.rf_we    = wb_q.valid & wb_q.rf_we & (wb_q.rd != 5'd0);
   assign bus.rf_wR    = wb_q.rd;
   assign bus.rf_wD    = wd_c;
   assign bus.wb_valid = wb_q.valid;
   assign bus.instret  = instret_q;

endmodule
